// File: rtl/ti_pkg.sv
// Shared widths and share-packing helpers for the threshold-implementation S-box pipeline.
package ti_pkg;

    localparam int unsigned TI_NB  = 4;
    localparam int unsigned TI_NS  = 3;
    localparam int unsigned TI_NST = 2;
    localparam int unsigned MAXW   = 64;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned idx_width(input int unsigned nb, input int unsigned ns);
        return (ns - 1) * nb;
    endfunction

    function automatic int unsigned tbl_depth(input int unsigned nb, input int unsigned ns);
        return 2 ** idx_width(nb, ns);
    endfunction

    function automatic logic [MAXW-1:0] share_get(input logic [MAXW-1:0] sh,
                                                  input int unsigned nb,
                                                  input int unsigned k);
        logic [MAXW-1:0] mask;
        mask = (MAXW'(1) << nb) - MAXW'(1);
        return (sh >> (k * nb)) & mask;
    endfunction

    // Concatenate every share except share i; lower k lands in lower bits.
    function automatic logic [MAXW-1:0] nc_index(input logic [MAXW-1:0] sh,
                                                 input int unsigned nb,
                                                 input int unsigned ns,
                                                 input int unsigned i);
        logic [MAXW-1:0] idx;
        int unsigned     pos;
        idx = '0;
        pos = 0;
        for (int unsigned k = 0; k < ns; k++) begin
            if (k != i) begin
                idx = idx | (share_get(sh, nb, k) << pos);
                pos = pos + nb;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ti_stage.sv
// One non-complete shared stage: per-bit loadable truth tables plus the glitch-stopping register.
module ti_stage
    import ti_pkg::*;
#(
    parameter  int unsigned NB    = TI_NB,
    parameter  int unsigned NS    = TI_NS,
    localparam int unsigned IW    = idx_width(NB, NS),
    localparam int unsigned SHW   = NS * NB,
    localparam int unsigned DEPTH = tbl_depth(NB, NS),
    localparam int unsigned SSW   = sel_width(NS),
    localparam int unsigned BSW   = sel_width(NB)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic           d_valid_i,
    input  logic [SHW-1:0] d_sh_i,
    output logic           q_valid_o,
    output logic [SHW-1:0] q_sh_o,
    input  logic           cfg_we_i,
    input  logic [SSW-1:0] cfg_share_i,
    input  logic [BSW-1:0] cfg_bit_i,
    input  logic [IW-1:0]  cfg_idx_i,
    input  logic           cfg_data_i
);

    logic [SHW-1:0] y_d;
    logic [SHW-1:0] sh_q;
    logic           valid_q;

    for (genvar gi = 0; gi < NS; gi++) begin : g_sh
        logic [IW-1:0] idx_c;
        assign idx_c = IW'(nc_index(MAXW'(d_sh_i), NB, NS, gi));

        for (genvar gb = 0; gb < NB; gb++) begin : g_bit
            logic [DEPTH-1:0] tbl_q;

            // Table contents survive reset on purpose.
            always_ff @(posedge clk) begin
                if (cfg_we_i && (cfg_share_i == SSW'(gi)) && (cfg_bit_i == BSW'(gb))) begin
                    tbl_q[cfg_idx_i] <= cfg_data_i;
                end
            end

            assign y_d[gi*NB+gb] = tbl_q[idx_c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            sh_q    <= '0;
        end else if (load_i) begin
            valid_q <= d_valid_i;
            if (d_valid_i) begin
                sh_q <= y_d;
            end
        end
    end

    assign q_valid_o = valid_q;
    assign q_sh_o    = sh_q;

endmodule

// File: rtl/ti_sbox_pipe.sv
// Pipelined TI S-box layer: NST registered shared stages with valid/ready flow control and table config.
module ti_sbox_pipe
    import ti_pkg::*;
#(
    parameter  int unsigned NB  = TI_NB,
    parameter  int unsigned NS  = TI_NS,
    parameter  int unsigned NST = TI_NST,
    localparam int unsigned IW  = idx_width(NB, NS),
    localparam int unsigned SHW = NS * NB,
    localparam int unsigned STW = sel_width(NST),
    localparam int unsigned SSW = sel_width(NS),
    localparam int unsigned BSW = sel_width(NB)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [SHW-1:0] in_sh,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SHW-1:0] out_sh,
    input  logic           cfg_we,
    input  logic [STW-1:0] cfg_stage,
    input  logic [SSW-1:0] cfg_share,
    input  logic [BSW-1:0] cfg_bit,
    input  logic [IW-1:0]  cfg_idx,
    input  logic           cfg_data,
    output logic           cfg_ready,
    output logic           busy
);

    logic [NST-1:0] valid_c;
    logic [NST-1:0] load_c;
    logic [SHW-1:0] sh_c [NST+1];
    logic           cfg_wr_c;

    // Load chain resolved from the output end back towards the input.
    always_comb begin
        logic ld;
        load_c = '0;
        ld     = out_ready;
        for (int s = NST - 1; s >= 0; s--) begin
            ld        = !valid_c[s] || ld;
            load_c[s] = ld;
        end
    end

    assign sh_c[0]  = in_sh;
    assign cfg_wr_c = cfg_we && cfg_ready;

    for (genvar gs = 0; gs < NST; gs++) begin : g_st
        logic d_valid_c;
        if (gs == 0) begin : g_first
            assign d_valid_c = in_valid;
        end else begin : g_rest
            assign d_valid_c = valid_c[gs-1];
        end

        ti_stage #(
            .NB (NB),
            .NS (NS)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .load_i      (load_c[gs]),
            .d_valid_i   (d_valid_c),
            .d_sh_i      (sh_c[gs]),
            .q_valid_o   (valid_c[gs]),
            .q_sh_o      (sh_c[gs+1]),
            .cfg_we_i    (cfg_wr_c && (cfg_stage == STW'(gs))),
            .cfg_share_i (cfg_share),
            .cfg_bit_i   (cfg_bit),
            .cfg_idx_i   (cfg_idx),
            .cfg_data_i  (cfg_data)
        );
    end

    assign in_ready  = load_c[0];
    assign busy      = |valid_c;
    assign cfg_ready = !busy && !in_valid;
    assign out_valid = valid_c[NST-1];
    assign out_sh    = sh_c[NST];

endmodule
